// File: rtl/gc_dram_pkg.sv
// gc_dram_pkg: shared geometry and word/row types for the gain-cell DRAM banks
package gc_dram_pkg;
    localparam int DATA_W = 64;
    localparam int DEPTH  = 128;
    localparam int ADDR_W = $clog2(DEPTH);
    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;
endpackage

// File: rtl/gc_mem_array.sv
// gc_mem_array: storage array with user/refresh write ports and one registered read port
module gc_mem_array
    import gc_dram_pkg::*;
#(
    parameter int DATA_W = gc_dram_pkg::DATA_W,
    parameter int DEPTH  = gc_dram_pkg::DEPTH,
    parameter int ADDR_W = gc_dram_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              u_we,
    input  logic [ADDR_W-1:0] u_addr,
    input  logic [DATA_W-1:0] u_data,
    input  logic              r_we,
    input  logic [ADDR_W-1:0] r_addr,
    input  logic [DATA_W-1:0] r_data,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] q
);
    logic [DATA_W-1:0] mem [DEPTH];
    // refresh write first so a same-row user write overrides it
    always_ff @(posedge clk) begin
        if (r_we) mem[r_addr] <= r_data;
        if (u_we) mem[u_addr] <= u_data;
    end
    // read sees pre-write contents; output holds when not reading
    always_ff @(posedge clk) begin
        if (!rst) q <= '0;
        else if (re) q <= mem[raddr];
    end
endmodule

// File: rtl/gc_mem_bank.sv
// gc_mem_bank: DRAM bank acting as user memory, refresh destination and refresh source
module gc_mem_bank
    import gc_dram_pkg::*;
#(
    parameter int DATA_W = gc_dram_pkg::DATA_W,
    parameter int DEPTH  = gc_dram_pkg::DEPTH,
    parameter int ADDR_W = gc_dram_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] u_data_in,
    input  logic [ADDR_W-1:0] u_write_addr,
    input  logic              u_we_current,
    input  logic [ADDR_W-1:0] u_read_addr,
    input  logic              u_re_current,
    input  logic              u_we_old,
    input  logic              u_re_old,
    input  logic              ref_en_old,
    input  logic [DATA_W-1:0] ref_data_in,
    input  logic [ADDR_W-1:0] sr_addr_old,
    input  logic              sr_ref_indicator_old,
    input  logic              sr_u_indicator_old,
    input  logic              ref_en_current,
    input  logic              start_SR,
    output logic [ADDR_W-1:0] sr_addr_current_out,
    output logic              sr_ref_indicator_current_out,
    output logic              sr_u_indicator_out,
    output logic              ref_done,
    output logic [DATA_W-1:0] rd
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
    logic [DEPTH-1:0]  dirty;
    logic [ADDR_W-1:0] cnt;
    logic              active, u_we, ref_we, stream, unused_ok;
    // write enables, stream qualification and read-port steering
    always_comb begin
        u_we      = u_we_current | (u_we_old & ref_en_old);
        ref_we    = ref_en_old & ~sr_u_indicator_old & ~dirty[sr_addr_old];
        stream    = ref_en_current & active & ~u_re_current;
        unused_ok = u_re_old ^ sr_ref_indicator_old;
    end
    // rows user-written during a refresh must not be overwritten by stale refresh data
    always_ff @(posedge clk) begin
        if (!rst || start_SR) dirty <= '0;
        else if (u_we && (ref_en_old || ref_en_current)) dirty[u_write_addr] <= 1'b1;
    end
    // source sweep counter and stream status outputs; counter stops after the last row
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt                          <= '0;
            active                       <= 1'b0;
            sr_addr_current_out          <= '0;
            sr_ref_indicator_current_out <= 1'b0;
            sr_u_indicator_out           <= 1'b0;
            ref_done                     <= 1'b0;
        end else begin
            sr_ref_indicator_current_out <= stream;
            sr_u_indicator_out           <= stream & u_we_current & (u_write_addr == cnt);
            ref_done                     <= stream & (cnt == LAST);
            if (stream) sr_addr_current_out <= cnt;
            if (start_SR && ref_en_current) begin
                cnt    <= '0;
                active <= 1'b1;
            end else if (stream) begin
                cnt    <= (cnt == LAST) ? cnt : cnt + 1'b1;
                active <= cnt != LAST;
            end
        end
    end
    gc_mem_array #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_array (
        .clk    (clk),
        .rst    (rst),
        .u_we   (u_we),
        .u_addr (u_write_addr),
        .u_data (u_data_in),
        .r_we   (ref_we),
        .r_addr (sr_addr_old),
        .r_data (ref_data_in),
        .re     (u_re_current | stream),
        .raddr  (u_re_current ? u_read_addr : cnt),
        .q      (rd)
    );
endmodule

// File: tb/tb_gc_mem_bank.sv
// tb_gc_mem_bank: directed vector and sequence bench for gc_mem_bank
module tb_gc_mem_bank;
    import gc_dram_pkg::*;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic  rst, u_we_current, u_re_current, u_we_old, u_re_old, ref_en_old;
    logic  sr_ref_indicator_old, sr_u_indicator_old, ref_en_current, start_SR;
    logic  sr_ref_indicator_current_out, sr_u_indicator_out, ref_done;
    word_t u_data_in, ref_data_in, rd;
    addr_t u_write_addr, u_read_addr, sr_addr_old, sr_addr_current_out;
    int    checks = 0, errors = 0, done_cnt;
    word_t expm [DEPTH];

    gc_mem_bank dut (
        .clk(clk), .rst(rst), .u_data_in(u_data_in), .u_write_addr(u_write_addr),
        .u_we_current(u_we_current), .u_read_addr(u_read_addr), .u_re_current(u_re_current),
        .u_we_old(u_we_old), .u_re_old(u_re_old), .ref_en_old(ref_en_old),
        .ref_data_in(ref_data_in), .sr_addr_old(sr_addr_old),
        .sr_ref_indicator_old(sr_ref_indicator_old), .sr_u_indicator_old(sr_u_indicator_old),
        .ref_en_current(ref_en_current), .start_SR(start_SR),
        .sr_addr_current_out(sr_addr_current_out),
        .sr_ref_indicator_current_out(sr_ref_indicator_current_out),
        .sr_u_indicator_out(sr_u_indicator_out), .ref_done(ref_done), .rd(rd)
    );

    typedef struct {
        logic  we;
        addr_t wa;
        word_t wd;
        logic  re;
        addr_t ra;
        word_t exp_rd;
    } vec_t;
    vec_t tbl [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        {u_we_current, u_re_current, u_we_old, u_re_old, ref_en_old} = '0;
        {sr_ref_indicator_old, sr_u_indicator_old, ref_en_current, start_SR} = '0;
        u_data_in = '0; ref_data_in = '0;
        u_write_addr = '0; u_read_addr = '0; sr_addr_old = '0;
    endtask

    task automatic start_dest;
        ref_en_old = 1'b1; start_SR = 1'b1;
        tick();
        start_SR = 1'b0;
    endtask

    task automatic readback(input string name);
        for (int i = 0; i < DEPTH; i++) begin
            u_re_current = 1'b1; u_read_addr = addr_t'(i);
            tick();
            chk($sformatf("%s row %0d", name, i), rd, expm[i]);
        end
        u_re_current = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b0;
        tick(); tick();
        chk("reset rd", rd, 0);
        chk("reset addr", sr_addr_current_out, 0);
        chk("reset ref_ind", sr_ref_indicator_current_out, 0);
        chk("reset u_ind", sr_u_indicator_out, 0);
        chk("reset done", ref_done, 0);
        rst = 1'b1;

        tbl[0] = '{1'b1, 7'd10, 64'd9,    1'b0, 7'd0,  64'd0};
        tbl[1] = '{1'b0, 7'd0,  64'd0,    1'b1, 7'd10, 64'd9};
        tbl[2] = '{1'b1, 7'd3,  64'h55,   1'b1, 7'd10, 64'd9};
        tbl[3] = '{1'b1, 7'd10, 64'h77,   1'b1, 7'd10, 64'd9};
        tbl[4] = '{1'b0, 7'd0,  64'd0,    1'b1, 7'd10, 64'h77};
        tbl[5] = '{1'b0, 7'd0,  64'd0,    1'b1, 7'd3,  64'h55};
        tbl[6] = '{1'b0, 7'd0,  64'd0,    1'b0, 7'd0,  64'h55};
        for (int v = 0; v < 7; v++) begin
            u_we_current = tbl[v].we; u_write_addr = tbl[v].wa; u_data_in = tbl[v].wd;
            u_re_current = tbl[v].re; u_read_addr = tbl[v].ra;
            tick();
            chk($sformatf("vec %0d rd", v), rd, tbl[v].exp_rd);
        end
        idle_inputs();

        start_dest();
        for (int i = 0; i < DEPTH; i++) begin
            sr_addr_old = addr_t'(i); ref_data_in = word_t'(i + 1);
            tick();
            expm[i] = word_t'(i + 1);
        end
        idle_inputs();
        readback("fill");

        start_dest();
        for (int i = 0; i < DEPTH; i++) begin
            sr_addr_old = addr_t'(i); ref_data_in = word_t'(i + 1);
            u_we_old = 1'b1; u_write_addr = addr_t'(i); u_data_in = word_t'(900 + i);
            tick();
            expm[i] = word_t'(900 + i);
        end
        idle_inputs();
        readback("collision");

        start_dest();
        for (int i = 0; i < DEPTH; i++) begin
            sr_addr_old = addr_t'(i); ref_data_in = word_t'(i + 1);
            u_we_current = (i == 5); u_write_addr = 7'd100; u_data_in = 64'hAA;
            sr_u_indicator_old = (i == 7);
            tick();
            expm[i] = (i == 7) ? expm[i] : word_t'(i + 1);
        end
        expm[100] = 64'hAA;
        idle_inputs();
        readback("dirty");

        u_we_old = 1'b1; u_write_addr = 7'd5; u_data_in = 64'hDEAD;
        tick();
        u_we_old = 1'b0; u_re_current = 1'b1; u_read_addr = 7'd5;
        tick();
        chk("we_old ignored", rd, expm[5]);
        idle_inputs();

        for (int i = 0; i < DEPTH; i++) begin
            u_we_current = 1'b1; u_write_addr = addr_t'(i); u_data_in = word_t'(32'h1000 + i);
            tick();
        end
        idle_inputs();
        ref_en_current = 1'b1; start_SR = 1'b1;
        tick();
        start_SR = 1'b0;
        chk("start ref_ind", sr_ref_indicator_current_out, 0);
        done_cnt = 0;
        for (int r = 0; r < DEPTH; r++) begin
            if (r == 50) begin
                u_re_current = 1'b1; u_read_addr = 7'd3;
                tick();
                u_re_current = 1'b0;
                chk("stall rd", rd, 64'h1003);
                chk("stall addr", sr_addr_current_out, 49);
                chk("stall ref_ind", sr_ref_indicator_current_out, 0);
                done_cnt += int'(ref_done);
            end
            u_we_current = (r == 20); u_write_addr = 7'd20; u_data_in = 64'h1014;
            tick();
            u_we_current = 1'b0;
            chk($sformatf("sweep addr %0d", r), sr_addr_current_out, r);
            chk($sformatf("sweep rd %0d", r), rd, 64'h1000 + r);
            chk($sformatf("sweep ref_ind %0d", r), sr_ref_indicator_current_out, 1);
            chk($sformatf("sweep u_ind %0d", r), sr_u_indicator_out, (r == 20));
            chk($sformatf("sweep done %0d", r), ref_done, (r == DEPTH - 1));
            done_cnt += int'(ref_done);
        end
        tick();
        done_cnt += int'(ref_done);
        chk("done count", done_cnt, 1);
        chk("post addr hold", sr_addr_current_out, 127);
        chk("post ref_ind", sr_ref_indicator_current_out, 0);
        chk("post rd hold", rd, 64'h107F);

        start_SR = 1'b1;
        tick();
        start_SR = 1'b0;
        for (int r = 0; r <= 60; r++) tick();
        chk("mid addr", sr_addr_current_out, 60);
        rst = 1'b0;
        tick();
        chk("midrst rd", rd, 0);
        chk("midrst addr", sr_addr_current_out, 0);
        chk("midrst ref_ind", sr_ref_indicator_current_out, 0);
        chk("midrst u_ind", sr_u_indicator_out, 0);
        chk("midrst done", ref_done, 0);
        rst = 1'b1;
        tick();
        chk("after rst no stream", sr_ref_indicator_current_out, 0);
        start_SR = 1'b1;
        tick();
        start_SR = 1'b0;
        tick();
        chk("restart addr", sr_addr_current_out, 0);
        chk("restart ref_ind", sr_ref_indicator_current_out, 1);
        chk("restart rd", rd, 64'h1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
